// File: rtl/tile_sequencer_if.sv
// Host/core handshake bundle for tile_sequencer; the abort signal exists only under SEQ_ABORT_EN.
// Latency: none (wires only); no backpressure is carried by this bundle.
interface tile_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic                    start;
  logic                    ofifo_valid;
  logic [2*ADDR_W+11:0]    inst;
  logic                    busy;
  logic                    done;
  logic [3:0]              kij_idx;
`ifdef SEQ_ABORT_EN
  logic                    abort;

  modport slave (input start, ofifo_valid, abort, output inst, busy, done, kij_idx);
  modport master (output start, ofifo_valid, abort, input inst, busy, done, kij_idx);
`else
  modport slave (input start, ofifo_valid, output inst, busy, done, kij_idx);
  modport master (output start, ofifo_valid, input inst, busy, done, kij_idx);
`endif
endinterface

// File: rtl/tile_sequencer.sv
// Per-tile core instruction sequencer: per kij loads weights, streams activations, drains OFIFO into pmem.
// All outputs registered (1-cycle); stalls only in WAITO on ofifo_valid. SEQ_ABORT_EN adds an abort input.
module tile_sequencer #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int ADDR_W = 11,
  parameter int NACT   = 36,
  parameter int NKIJ   = 9,
  parameter int W_BASE = 128,
  parameter int X_BASE = 0,
  parameter int P_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  tile_sequencer_if.slave  bus
);
  localparam int M1    = (col + 1 > NACT + 1) ? col + 1 : NACT + 1;
  localparam int MAXC  = (M1 > row) ? M1 : row;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(col);
  localparam logic [CNT_W-1:0] KLD_LAST = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(row - 1);
  localparam logic [CNT_W-1:0] XL_LAST  = CNT_W'(NACT);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(NACT - 1);
  localparam logic [3:0]       KIJ_LAST = 4'(NKIJ - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_KLD, S_KGAP, S_XL0, S_EXE, S_WAITO, S_ORD, S_DONE
  } state_t;

  typedef struct packed {
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  function automatic inst_t idle_inst();
    inst_t t;
    t          = '0;
    t.cen_pmem = 1'b1;
    t.wen_pmem = 1'b1;
    t.cen_xmem = 1'b1;
    t.wen_xmem = 1'b1;
    return t;
  endfunction

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [3:0]       kij, nkij;
  inst_t            inst_q, ninst;
  logic             busy_q, done_q;

  always_comb begin
    nstate = state;
    ncnt   = cnt + CNT_W'(1);
    nkij   = kij;
    case (state)
      S_IDLE: begin
        ncnt = '0;
        nkij = '0;
        if (bus.start) nstate = S_WL0;
      end
      S_WL0:  if (cnt == WL_LAST)  begin nstate = S_KLD;  ncnt = '0; end
      S_KLD:  if (cnt == KLD_LAST) begin nstate = S_KGAP; ncnt = '0; end
      S_KGAP: if (cnt == GAP_LAST) begin nstate = S_XL0;  ncnt = '0; end
      S_XL0:  if (cnt == XL_LAST)  begin nstate = S_EXE;  ncnt = '0; end
      S_EXE:  if (cnt == ACT_LAST) begin nstate = S_WAITO; ncnt = '0; end
      S_WAITO: begin
        ncnt = '0;
        if (bus.ofifo_valid) nstate = S_ORD;
      end
      S_ORD: begin
        if (cnt == ACT_LAST) begin
          ncnt = '0;
          if (kij == KIJ_LAST) begin
            nstate = S_DONE;
          end else begin
            nstate = S_WL0;
            nkij   = kij + 4'd1;
          end
        end
      end
      S_DONE: begin
        nstate = S_IDLE;
        ncnt   = '0;
        nkij   = '0;
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = '0;
        nkij   = '0;
      end
    endcase
`ifdef SEQ_ABORT_EN
    // Abort also masks a same-cycle start while idle.
    if (bus.abort) begin
      nstate = S_IDLE;
      ncnt   = '0;
      nkij   = '0;
    end
`endif
  end

  // Instruction is decoded from the next state so it lines up with the registered state.
  always_comb begin
    ninst = idle_inst();
    case (nstate)
      S_WL0: begin
        if (ncnt < WL_LAST) begin
          ninst.cen_xmem = 1'b0;
          ninst.a_xmem   = ADDR_W'(W_BASE) + ADDR_W'(nkij) * ADDR_W'(col) + ADDR_W'(ncnt);
        end
        ninst.l0_wr = (ncnt != '0);
      end
      S_KLD: begin
        ninst.load  = 1'b1;
        ninst.l0_rd = 1'b1;
      end
      S_XL0: begin
        if (ncnt < XL_LAST) begin
          ninst.cen_xmem = 1'b0;
          ninst.a_xmem   = ADDR_W'(X_BASE) + ADDR_W'(ncnt);
        end
        ninst.l0_wr = (ncnt != '0);
      end
      S_EXE: begin
        ninst.execute = 1'b1;
        ninst.l0_rd   = 1'b1;
      end
      S_ORD: begin
        ninst.ofifo_rd = 1'b1;
        ninst.cen_pmem = 1'b0;
        ninst.wen_pmem = 1'b0;
        ninst.a_pmem   = ADDR_W'(P_BASE) + ADDR_W'(ncnt);
        ninst.acc      = (nkij != '0);
      end
      default: ninst = idle_inst();
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      kij    <= '0;
      inst_q <= idle_inst();
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      kij    <= nkij;
      inst_q <= ninst;
      busy_q <= (nstate != S_IDLE);
      done_q <= (nstate == S_DONE);
    end
  end

  assign bus.inst    = inst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.kij_idx = kij;
endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Drives the 34-bit core instruction word for one output tile of a convolution-as-matmul pass on the row x col systolic core.
- For each kernel index kij it loads weights from xmem into L0, pushes them into the array, streams activations, drains the OFIFO and writes or accumulates psums into pmem.
- Sits between the top-level testbench/host and the core: it replaces hand-sequenced inst vectors.

Parameters:
- row, 8, array rows (activation lanes)
- col, 8, array columns (weight words per kij)
- ADDR_W, 11, xmem/pmem address width
- NACT, 36, activation vectors per tile (psum rows written per kij)
- NKIJ, 9, kernel positions accumulated per tile
- W_BASE, 128, xmem base address of weights; kij block at W_BASE + kij*col
- X_BASE, 0, xmem base address of activations
- P_BASE, 0, pmem base address of psums

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  begin tile; sampled only in IDLE
- ofifo_valid  in  1  core OFIFO holds a full psum row set
- inst  out  34  core instruction word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last kij completes
- kij_idx  out  4  current kernel index

Behaviour:
- inst field map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- Memory enables are active low.
- IDLE_INST: CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1, all other bits 0.
- All outputs are registered. On reset: state=IDLE, inst=IDLE_INST, busy=0, done=0, kij_idx=0, counters=0.
- FSM:
  - IDLE --start--> WL0. kij_idx=0.
  - WL0, col+1 cycles, cnt=0..col. While cnt<col: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+kij*col+cnt. While cnt>=1: l0_wr=1. The extra cycle covers the 1-cycle SRAM read latency.
  - KLD, col cycles: load=1, l0_rd=1.
  - KGAP, row cycles: IDLE_INST. This lets weights settle down the columns.
  - XL0, NACT+1 cycles: same pattern as WL0 with A_xmem=X_BASE+cnt.
  - EXE, NACT cycles: execute=1, l0_rd=1.
  - WAITO: IDLE_INST until ofifo_valid=1, with no timeout.
  - ORD, NACT cycles: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=P_BASE+cnt, acc=(kij_idx!=0). The OFIFO is show-ahead, so data is valid in the same cycle.
  - After ORD: if kij_idx==NKIJ-1, go to DONE. Otherwise increment kij_idx and go to WL0.
  - DONE, 1 cycle: done=1, inst=IDLE_INST. Then go to IDLE; kij_idx resets to 0 on return to IDLE.
- start while busy is ignored. start held high in IDLE after DONE begins a new tile on the next IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W with wrap-around and no error.
- Reset asserted mid-tile aborts immediately. The next cycle shows reset values, with no done pulse.
- Cycles per kij: (col+1)+col+row+(NACT+1)+NACT+W+NACT, where W is the number of WAITO cycles including the exit cycle (W>=1). Defaults give 134+W.

Optional Feature:
- Macro SEQ_ABORT_EN.
- When defined: adds input port abort (1 bit). abort=1 in any state other than IDLE forces state=IDLE, inst=IDLE_INST, busy=0 and kij_idx=0 on the next edge, with no done pulse. abort has priority over start in the same cycle.
- When undefined: no abort port, and the tile can only be stopped by reset.

Test Plan:
- reset high 3 cycles, then low -> inst=IDLE_INST (CEN/WEN bits 1, rest 0), busy=0, done=0, kij_idx=0.
- NACT=4, NKIJ=2, start pulse, ofifo_valid tied 1 -> WL0 A_xmem 128..135 with l0_wr one cycle late; ORD kij0 acc=0 A_pmem 0..3; kij1 A_xmem 136..143, acc=1; single done pulse; busy high for exactly 2*(9+8+8+5+4+1+4)+1 = 79 cycles.
- Hold ofifo_valid=0 for 20 cycles in WAITO -> inst stays IDLE_INST, state unchanged; ofifo_rd rises the cycle after ofifo_valid goes high.
- Pulse start during EXE -> ignored: no restart, kij_idx and cnt unchanged.
- Assert reset during ORD -> next cycle all outputs at reset values, no done pulse; a fresh start replays from kij 0.
- With SEQ_ABORT_EN, assert abort and start together during KLD -> IDLE next cycle, busy=0, no done pulse; start ignored.
